// File: rtl/nn_neuron_seq_if.sv
// Handshake/config bundle for nn_neuron_seq: config write port, input vector and result channels.
interface nn_neuron_seq_if #(
  parameter int DATAWIDTH = 32,
  parameter int N_IN      = 4
);
  localparam int CFG_AW = $clog2(2 * N_IN + 2);

  logic                      cfg_we;
  logic [CFG_AW-1:0]         cfg_addr;
  logic [DATAWIDTH-1:0]      cfg_wdata;
  logic                      in_valid;
  logic                      in_ready;
  logic [N_IN*DATAWIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATAWIDTH-1:0]      out_data;
  logic                      ovf;
  logic [2:0]                ovf_stage;
  logic                      zero;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, ovf, ovf_stage, zero
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, ovf, ovf_stage, zero
  );
endinterface

// File: rtl/nn_neuron_seq.sv
// Time-multiplexed neuron: pre-shift, single-multiplier MAC, bias, post-shift, saturate on overflow.
// Define NN_RELU_EN to clamp non-overflowed negative results to zero.
module nn_neuron_seq #(
  parameter int DATAWIDTH = 32,
  parameter int N_IN      = 4
) (
  input logic           clk,
  input logic           resetn,
  nn_neuron_seq_if.slave bus
);
  localparam int W      = DATAWIDTH;
  localparam int CFG_AW = $clog2(2 * N_IN + 2);
  localparam int IDX_W  = $clog2(N_IN);
  localparam logic [W-1:0]     SH_LIM   = W'(W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_MAC, S_BIAS, S_POST, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [W-1:0]     weight_reg   [N_IN];
  logic [W-1:0]     preshift_reg [N_IN];
  logic [W-1:0]     data_reg     [N_IN];
  logic [W-1:0]     pre_x        [N_IN];
  logic [W-1:0]     bias_reg, postshift_reg;
  logic [W-1:0]     acc_reg;
  logic [2:0]       flags_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [W-1:0]     out_data_reg;
  logic             ovf_reg, zero_reg;
  logic [2:0]       ovf_stage_reg;

  logic in_ready_c, out_valid_c, accept, cfg_wr;

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (bus.in_valid) state_next = S_PRE;
      S_PRE:  state_next = S_MAC;
      S_MAC:  if (idx_reg == IDX_LAST) state_next = S_BIAS;
      S_BIAS: state_next = S_POST;
      S_POST: state_next = S_DONE;
      S_DONE: if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = (state_reg == S_IDLE);
    out_valid_c = (state_reg == S_DONE);
    accept      = in_ready_c && bus.in_valid;
    cfg_wr      = in_ready_c && bus.cfg_we;
  end

  // Config writes only land while idle so a pass always sees one consistent setting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_IN; i++) begin
        weight_reg[i]   <= '0;
        preshift_reg[i] <= '0;
      end
      bias_reg      <= '0;
      postshift_reg <= '0;
    end else if (cfg_wr) begin
      for (int i = 0; i < N_IN; i++) begin
        if (bus.cfg_addr == CFG_AW'(i))        weight_reg[i]   <= bus.cfg_wdata;
        if (bus.cfg_addr == CFG_AW'(N_IN + i)) preshift_reg[i] <= bus.cfg_wdata;
      end
      if (bus.cfg_addr == CFG_AW'(2 * N_IN))     bias_reg      <= bus.cfg_wdata;
      if (bus.cfg_addr == CFG_AW'(2 * N_IN + 1)) postshift_reg <= bus.cfg_wdata;
    end
  end

  // Arithmetic pre-shift; amounts of W or more collapse to sign fill.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_pre
    assign pre_x[gi] = (preshift_reg[gi] >= SH_LIM) ? {W{data_reg[gi][W-1]}}
                                                    : $unsigned($signed(data_reg[gi]) >>> preshift_reg[gi]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_IN; i++) data_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_IN; i++) data_reg[i] <= bus.in_data[i*W +: W];
    end else if (state_reg == S_PRE) begin
      for (int i = 0; i < N_IN; i++) data_reg[i] <= pre_x[i];
    end
  end

  logic [W-1:0]   x_cur, w_cur, add_b, sum, result;
  logic [2*W-1:0] prod, post_wide;
  logic           mul_ovf, add_ovf, post_ovf, any_ovf;
  logic [2:0]     post_flags;

  always_comb begin
    x_cur      = data_reg[idx_reg];
    w_cur      = weight_reg[idx_reg];
    prod       = {{W{x_cur[W-1]}}, x_cur} * {{W{w_cur[W-1]}}, w_cur};
    mul_ovf    = (prod[2*W-1:W] != {W{prod[W-1]}});
    add_b      = (state_reg == S_BIAS) ? bias_reg : prod[W-1:0];
    sum        = acc_reg + add_b;
    add_ovf    = (acc_reg[W-1] == add_b[W-1]) && (sum[W-1] != acc_reg[W-1]);
    post_wide  = {{W{acc_reg[W-1]}}, acc_reg} << postshift_reg;
    post_ovf   = (post_wide[2*W-1:W] != {W{post_wide[W-1]}}) ||
                 ((postshift_reg >= SH_LIM) && (acc_reg != '0));
    post_flags = flags_reg | {post_ovf, 2'b00};
    any_ovf    = |post_flags;
  end

`ifdef NN_RELU_EN
  assign result = any_ovf ? '1 : (post_wide[W-1] ? '0 : post_wide[W-1:0]);
`else
  assign result = any_ovf ? '1 : post_wide[W-1:0];
`endif

  // Later stages keep computing after an overflow; flags only accumulate.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_reg       <= '0;
      flags_reg     <= '0;
      idx_reg       <= '0;
      out_data_reg  <= '0;
      ovf_reg       <= 1'b0;
      ovf_stage_reg <= '0;
      zero_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (accept) begin
          acc_reg   <= '0;
          flags_reg <= '0;
          idx_reg   <= '0;
        end
        S_MAC: begin
          acc_reg   <= sum;
          flags_reg <= flags_reg | {1'b0, add_ovf, mul_ovf};
          idx_reg   <= idx_reg + IDX_W'(1);
        end
        S_BIAS: begin
          acc_reg   <= sum;
          flags_reg <= flags_reg | {1'b0, add_ovf, 1'b0};
        end
        S_POST: begin
          flags_reg     <= post_flags;
          out_data_reg  <= result;
          ovf_reg       <= any_ovf;
          ovf_stage_reg <= post_flags;
          zero_reg      <= (result == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.ovf_stage = ovf_stage_reg;
  assign bus.zero      = zero_reg;
endmodule

// File: tb/tb_nn_neuron_seq.sv
// Directed plus randomized bench for nn_neuron_seq, checked against an arithmetic reference model.
module tb_nn_neuron_seq;
  localparam int W = 32;
  localparam int N = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  nn_neuron_seq_if #(.DATAWIDTH(W), .N_IN(N)) bus ();
  nn_neuron_seq #(.DATAWIDTH(W), .N_IN(N)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_w [N];
  logic [31:0] m_pre [N];
  logic [31:0] m_bias, m_post;
  logic [31:0] cur_in [N];
  logic [31:0] e_data;
  logic        e_ovf, e_zero;
  logic [2:0]  e_st;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic with range checks for each stage.
  task automatic model();
    int acc, xi, wi;
    longint p, s, r;
    logic [2:0]  st;
    logic [31:0] rlo;
    acc = 0;
    st  = 3'b000;
    for (int i = 0; i < N; i++) begin
      xi = int'(cur_in[i]);
      if (m_pre[i] >= 32) xi = (xi < 0) ? -1 : 0;
      else                xi = xi >>> m_pre[i];
      wi = int'(m_w[i]);
      p  = longint'(xi) * longint'(wi);
      if (p > MAXV || p < MINV) st[0] = 1'b1;
      s = longint'(acc) + longint'(int'(p));
      if (s > MAXV || s < MINV) st[1] = 1'b1;
      acc = int'(s);
    end
    s = longint'(acc) + longint'(int'(m_bias));
    if (s > MAXV || s < MINV) st[1] = 1'b1;
    acc = int'(s);
    if (m_post >= 32) begin
      if (acc != 0) st[2] = 1'b1;
      rlo = 32'd0;
    end else begin
      r = longint'(acc) <<< m_post;
      if (r > MAXV || r < MINV) st[2] = 1'b1;
      rlo = r[31:0];
    end
    e_st   = st;
    e_ovf  = |st;
    e_data = e_ovf ? 32'hFFFF_FFFF : rlo;
`ifdef NN_RELU_EN
    if (!e_ovf && rlo[31]) e_data = 32'd0;
`endif
    e_zero = (e_data == 32'd0);
  endtask

  task automatic shadow_write(input logic [3:0] a, input logic [31:0] d);
    if (a < 4)       m_w[a[1:0]]   = d;
    else if (a < 8)  m_pre[a[1:0]] = d;
    else if (a == 8) m_bias        = d;
    else if (a == 9) m_post        = d;
  endtask

  task automatic shadow_clear();
    for (int i = 0; i < N; i++) begin
      m_w[i]   = 32'd0;
      m_pre[i] = 32'd0;
    end
    m_bias = 32'd0;
    m_post = 32'd0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    shadow_write(a, d);
  endtask

  task automatic set_in(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    cur_in[0] = a; cur_in[1] = b; cur_in[2] = c; cur_in[3] = d;
  endtask

  task automatic start_pass(input logic with_cfg, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = cur_in[i];
    bus.in_valid = 1'b1;
    if (with_cfg) begin
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_wdata = d;
      shadow_write(a, d);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int already);
    int lat;
    lat = already;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 40);
    check({tag, " latency"}, lat, 32'd7);
    model();
    check({tag, " out_data"}, bus.out_data, e_data);
    check({tag, " ovf"}, bus.ovf, e_ovf);
    check({tag, " ovf_stage"}, bus.ovf_stage, e_st);
    check({tag, " zero"}, bus.zero, e_zero);
  endtask

  task automatic finish_pass(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " out_valid after take"}, bus.out_valid, 1'b0);
    check({tag, " in_ready after take"}, bus.in_ready, 1'b1);
  endtask

  function automatic logic [31:0] rnd_val();
    int v;
    if ($urandom_range(0, 3) == 0) return $urandom;
    v = int'($urandom_range(0, 2000)) - 1000;
    return 32'(v);
  endfunction

  function automatic logic [31:0] rnd_shift();
    if ($urandom_range(0, 5) == 0) return 32'($urandom_range(28, 40));
    return 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] held;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    shadow_clear();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", bus.in_ready, 1'b1);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset out_data", bus.out_data, 32'd0);
    check("reset ovf", bus.ovf, 1'b0);
    check("reset ovf_stage", bus.ovf_stage, 3'b000);
    check("reset zero", bus.zero, 1'b0);
    resetn = 1'b1;

    // Basic pass
    cfg_write(4'd0, 32'd2);
    cfg_write(4'd1, 32'd3);
    cfg_write(4'd2, 32'hFFFF_FFFF);
    cfg_write(4'd3, 32'd1);
    cfg_write(4'd8, 32'd5);
    cfg_write(4'd9, 32'd1);
    set_in(32'd10, 32'd20, 32'd30, 32'd40);
    start_pass(1'b0, 4'd0, 32'd0);
    wait_result("basic", 0);
    check("basic const", bus.out_data, 32'd190);
    finish_pass("basic");

    // Multiplier overflow
    cfg_write(4'd0, 32'h4000_0000);
    set_in(32'd4, 32'd0, 32'd0, 32'd0);
    start_pass(1'b0, 4'd0, 32'd0);
    wait_result("mulovf", 0);
    check("mulovf const data", bus.out_data, 32'hFFFF_FFFF);
    check("mulovf const stage", bus.ovf_stage, 3'b001);
    finish_pass("mulovf");

    // Pre-shift sign handling
    cfg_write(4'd0, 32'd3);
    cfg_write(4'd4, 32'd2);
    cfg_write(4'd8, 32'd0);
    cfg_write(4'd9, 32'd0);
    set_in(32'hFFFF_FFF8, 32'd0, 32'd0, 32'd0);
    start_pass(1'b0, 4'd0, 32'd0);
    wait_result("preshift", 0);
`ifdef NN_RELU_EN
    check("preshift const", bus.out_data, 32'd0);
`else
    check("preshift const", bus.out_data, 32'hFFFF_FFFA);
`endif
    finish_pass("preshift");

    // Bias cancels to zero
    cfg_write(4'd0, 32'd2);
    cfg_write(4'd4, 32'd0);
    cfg_write(4'd8, 32'hFFFF_FFA6);
    cfg_write(4'd9, 32'd1);
    set_in(32'd10, 32'd20, 32'd30, 32'd40);
    start_pass(1'b0, 4'd0, 32'd0);
    wait_result("zerobias", 0);
    check("zerobias const zero", bus.zero, 1'b1);
    finish_pass("zerobias");

    // Backpressure: held result, extra input ignored
    cfg_write(4'd8, 32'd5);
    start_pass(1'b0, 4'd0, 32'd0);
    wait_result("bp", 0);
    held = bus.out_data;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {4{32'd7}};
      @(posedge clk);
      @(negedge clk);
      check("bp held data", bus.out_data, held);
      check("bp in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    finish_pass("bp");
    repeat (10) @(negedge clk);
    check("bp no buffered pass", bus.out_valid, 1'b0);

    // Config write while busy is dropped
    start_pass(1'b0, 4'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'd0;
    bus.cfg_wdata = 32'd100;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    wait_result("busycfg", 2);
    check("busycfg const", bus.out_data, 32'd190);
    finish_pass("busycfg");

    // Reset mid-MAC
    start_pass(1'b0, 4'd0, 32'd0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    resetn = 1'b0;
    #1;
    check("midrst in_ready", bus.in_ready, 1'b1);
    check("midrst out_valid", bus.out_valid, 1'b0);
    check("midrst out_data", bus.out_data, 32'd0);
    check("midrst ovf_stage", bus.ovf_stage, 3'b000);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    shadow_clear();
    start_pass(1'b0, 4'd0, 32'd0);
    wait_result("postrst", 0);
    check("postrst const", bus.out_data, 32'd0);
    finish_pass("postrst");

    // Config write in the accepting cycle is used by that pass
    cfg_write(4'd0, 32'd2);
    cfg_write(4'd1, 32'd3);
    cfg_write(4'd2, 32'hFFFF_FFFF);
    cfg_write(4'd3, 32'd1);
    cfg_write(4'd9, 32'd1);
    start_pass(1'b1, 4'd8, 32'd7);
    wait_result("samecyc", 0);
    check("samecyc const", bus.out_data, 32'd194);
    finish_pass("samecyc");

    // Randomized passes
    for (int t = 0; t < 20; t++) begin
      for (int a = 0; a < 4; a++) cfg_write(4'(a), rnd_val());
      for (int a = 4; a < 8; a++) cfg_write(4'(a), rnd_shift());
      cfg_write(4'd8, rnd_val());
      cfg_write(4'd9, rnd_shift());
      set_in(rnd_val(), rnd_val(), rnd_val(), rnd_val());
      if (t % 4 == 0) start_pass(1'b1, 4'd8, rnd_val());
      else            start_pass(1'b0, 4'd0, 32'd0);
      wait_result($sformatf("rand%0d", t), 0);
      finish_pass($sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
